// File: rtl/div_reg36x18.sv
// Iterative restoring divider, 36-bit dividend by 18-bit divisor.
// One quotient bit per RUN cycle, MSB first; divide-by-zero short-circuits to DONE.
module div_reg36x18 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [35:0] dividend,
  input  logic [17:0] divisor,
  output logic        ready,
  output logic        out_valid,
  output logic [35:0] quotient,
  output logic [17:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      r_state;
  logic [35:0] r_dividend;
  logic [17:0] r_divisor;
  logic [35:0] r_quot;
  logic [18:0] r_prem;
  logic [5:0]  r_cnt;
  logic        r_dbz;
  logic        r_ready;
  logic        r_valid;

  logic [18:0] w_shift;
  logic [19:0] w_diff;
  logic        w_ge;

  // r_prem[18] folded into the compare keeps the trial subtraction exact even if
  // the shifted partial remainder carried out of 19 bits.
  assign w_shift = {r_prem[17:0], r_dividend[35]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_divisor};
  assign w_ge    = r_prem[18] | ~w_diff[19];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_prem     <= '0;
      r_cnt      <= '0;
      r_dbz      <= 1'b0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (start) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_ready    <= 1'b0;
            if (divisor == 18'd0) begin
              r_quot  <= '1;
              r_prem  <= {1'b0, dividend[17:0]};
              r_dbz   <= 1'b1;
              r_valid <= 1'b1;
              r_state <= DONE;
            end else begin
              r_quot  <= '0;
              r_prem  <= '0;
              r_cnt   <= 6'd35;
              r_dbz   <= 1'b0;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_dividend <= {r_dividend[34:0], 1'b0};
          r_prem     <= w_ge ? w_diff[18:0] : w_shift;
          r_quot     <= {r_quot[34:0], w_ge};
          if (r_cnt == 6'd0) begin
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        DONE: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign out_valid   = r_valid;
  assign quotient    = r_quot;
  assign remainder   = r_prem[17:0];
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_reg36x18.sv
// Directed bench for div_reg36x18: reset, basic, extremes, divide-by-zero,
// busy-ignore, reset mid-run and back-to-back operations.
module tb_div_reg36x18;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [35:0] dividend;
  logic [17:0] divisor;
  logic        ready;
  logic        out_valid;
  logic [35:0] quotient;
  logic [17:0] remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  div_reg36x18 dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .out_valid(out_valid), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds start for one edge; returns in cycle 1 after the accept edge.
  task automatic do_accept(input logic [35:0] a, input logic [17:0] d);
    dividend = a;
    divisor  = d;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Returns the cycle index (counting from k0) at which out_valid is first seen, -1 on timeout.
  task automatic wait_valid(input int k0, output int lat);
    lat = -1;
    for (int k = k0; k <= k0 + 60; k++) begin
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; dividend = 36'd100; divisor = 18'd7;
    tick(); tick();
    reset = 1'b0; start = 1'b0;
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_tests++; if (quotient !== 36'd0) begin n_fail++; $display("FAIL reset_quot: got %h expected 0", quotient); end
    n_tests++; if (remainder !== 18'd0) begin n_fail++; $display("FAIL reset_rem: got %h expected 0", remainder); end
    n_tests++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    tick();
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ignored: ready %b expected 1", ready); end
  endtask

  task automatic test_basic();
    int lat;
    do_accept(36'd100, 18'd7);
    wait_valid(1, lat);
    n_tests++; if (lat != 37) begin n_fail++; $display("FAIL basic_latency: got %0d expected 37", lat); end
    n_tests++; if (quotient !== 36'd14) begin n_fail++; $display("FAIL basic_quot: got %0d expected 14", quotient); end
    n_tests++; if (remainder !== 18'd2) begin n_fail++; $display("FAIL basic_rem: got %0d expected 2", remainder); end
    n_tests++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_done: got %b expected 0", ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: out_valid %b expected 0", out_valid); end
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_idle: got %b expected 1", ready); end
    tick();
    n_tests++; if (quotient !== 36'd14 || remainder !== 18'd2) begin
      n_fail++; $display("FAIL basic_hold: got %0d/%0d expected 14/2", quotient, remainder);
    end
  endtask

  task automatic test_extremes();
    int lat;
    do_accept(36'hF_FFFF_FFFF, 18'h3FFFF);
    wait_valid(1, lat);
    n_tests++; if (lat != 37) begin n_fail++; $display("FAIL ext1_latency: got %0d expected 37", lat); end
    n_tests++; if (quotient !== 36'h0_0004_0001) begin n_fail++; $display("FAIL ext1_quot: got %h expected 000040001", quotient); end
    n_tests++; if (remainder !== 18'd0) begin n_fail++; $display("FAIL ext1_rem: got %h expected 0", remainder); end
    tick();
    do_accept(36'h9_ABCD_1234, 18'd1);
    wait_valid(1, lat);
    n_tests++; if (lat != 37) begin n_fail++; $display("FAIL ext2_latency: got %0d expected 37", lat); end
    n_tests++; if (quotient !== 36'h9_ABCD_1234) begin n_fail++; $display("FAIL ext2_quot: got %h expected 9abcd1234", quotient); end
    n_tests++; if (remainder !== 18'd0) begin n_fail++; $display("FAIL ext2_rem: got %h expected 0", remainder); end
    tick();
  endtask

  task automatic test_div_by_zero();
    int lat;
    do_accept(36'h0_0001_2345, 18'd0);
    wait_valid(1, lat);
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
    n_tests++; if (quotient !== 36'hF_FFFF_FFFF) begin n_fail++; $display("FAIL dbz_quot: got %h expected fffffffff", quotient); end
    n_tests++; if (remainder !== 18'h12345) begin n_fail++; $display("FAIL dbz_rem: got %h expected 12345", remainder); end
    n_tests++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
    tick();
    n_tests++; if (ready !== 1'b1 || div_by_zero !== 1'b1) begin
      n_fail++; $display("FAIL dbz_hold: ready %b dbz %b expected 1 1", ready, div_by_zero);
    end
    do_accept(36'd20, 18'd3);
    wait_valid(1, lat);
    n_tests++; if (div_by_zero !== 1'b0 || quotient !== 36'd6 || remainder !== 18'd2) begin
      n_fail++; $display("FAIL dbz_clear: got dbz %b q %0d r %0d expected 0 6 2", div_by_zero, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int lat;
    int extra;
    int not_ready;
    do_accept(36'd100, 18'd7);
    repeat (4) tick();
    dividend = 36'd50; divisor = 18'd5; start = 1'b1;
    repeat (3) tick();
    start = 1'b0; dividend = 36'd0; divisor = 18'd0;
    wait_valid(8, lat);
    n_tests++; if (lat != 37) begin n_fail++; $display("FAIL busy_latency: got %0d expected 37", lat); end
    n_tests++; if (quotient !== 36'd14 || remainder !== 18'd2) begin
      n_fail++; $display("FAIL busy_result: got %0d/%0d expected 14/2", quotient, remainder);
    end
    dividend = 36'd50; divisor = 18'd5; start = 1'b1;
    tick();
    start = 1'b0;
    extra = 0; not_ready = 0;
    for (int k = 0; k < 45; k++) begin
      if (out_valid === 1'b1) extra++;
      if (ready !== 1'b1) not_ready++;
      tick();
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL busy_no_second_valid: got %0d pulses expected 0", extra); end
    n_tests++; if (not_ready != 0) begin n_fail++; $display("FAIL busy_done_start_ignored: got %0d busy cycles expected 0", not_ready); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    do_accept(36'd100, 18'd7);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if (ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ctrl: ready %b valid %b expected 1 0", ready, out_valid);
    end
    n_tests++; if (quotient !== 36'd0 || remainder !== 18'd0 || div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: q %h r %h dbz %b expected 0 0 0", quotient, remainder, div_by_zero);
    end
    seen = 0;
    for (int k = 0; k < 45; k++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL midreset_no_valid: got %0d pulses expected 0", seen); end
    do_accept(36'd9, 18'd4);
    wait_valid(1, lat);
    n_tests++; if (lat != 37 || quotient !== 36'd2 || remainder !== 18'd1) begin
      n_fail++; $display("FAIL midreset_after: lat %0d q %0d r %0d expected 37 2 1", lat, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [35:0] a;
    logic [17:0] d;
    logic [63:0] eq, er, chk;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom_range(15, 0), $urandom()};
      d = 18'($urandom_range(262143, 1));
      if (i == 0) begin a = 36'd1; d = 18'd2; end
      if (i == 1) begin a = 36'd17; d = 18'd17; end
      eq = 64'(a) / 64'(d);
      er = 64'(a) % 64'(d);
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, ready); end
      do_accept(a, d);
      wait_valid(1, lat);
      chk = 64'(quotient) * 64'(d) + 64'(remainder);
      n_tests++; if (lat != 37) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected 37", i, lat); end
      n_tests++; if (quotient !== eq[35:0] || remainder !== er[17:0]) begin
        n_fail++; $display("FAIL b2b_result[%0d]: %h/%h got q %h r %h expected q %h r %h", i, a, d, quotient, remainder, eq[35:0], er[17:0]);
      end
      n_tests++; if (chk != 64'(a) || remainder >= d || div_by_zero !== 1'b0) begin
        n_fail++; $display("FAIL b2b_identity[%0d]: q*d+r %h got vs dividend %h required, r %h d %h", i, chk, a, remainder, d);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #2;
    test_reset();
    test_basic();
    test_extremes();
    test_div_by_zero();
    test_busy_ignore();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
